// File: rtl/fifo_flags.sv
// Synchronous show-ahead FIFO with occupancy count, programmable almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module fifo_flags #(
  parameter int B      = 8,
  parameter int W      = 4,
  parameter int AF_LVL = 2**W - 2,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] wr_data,
  input  logic         rd,
  output logic [B-1:0] rd_data,
  input  logic         flush,
  input  logic         clr_err,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int          DEPTH  = 2**W;
  localparam logic [W:0]  FULL_C = (W+1)'(DEPTH);
  localparam logic [W:0]  AF_C   = (W+1)'(AF_LVL);
  localparam logic [W:0]  AE_C   = (W+1)'(AE_LVL);

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;
  logic         rd_en;
  logic         wr_en;
  logic [W:0]   count_next;
  logic         ovf_set;
  logic         unf_set;

  // A pop frees a slot on the same edge, so a push is accepted at full when rd is high.
  assign rd_en      = rd & ~empty;
  assign wr_en      = wr & (~full | rd);
  assign count_next = count + {{W{1'b0}}, wr_en} - {{W{1'b0}}, rd_en};

  // Requests coinciding with a flush are discarded and must not raise errors.
  assign ovf_set = wr & full & ~rd & ~flush;
  assign unf_set = rd & empty & ~flush;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count        <= count_next;
      full         <= (count_next == FULL_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
    end
  end

  // A new error on the same edge as clr_err wins, so nothing is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

endmodule
